// File: rtl/vdp_cpu_port.sv
// CPU-side port of the TMS9918-style VDP. It decodes 0x98/0x99 accesses and owns the
// address/register latch, the auto-incrementing VRAM pointer, the read-ahead buffer and status/IRQ.
module vdp_cpu_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        cs_data,
    input  logic        cs_ctrl,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        wait_n,
    output logic        vram_req,
    output logic        vram_we,
    output logic [13:0] vram_addr,
    output logic [7:0]  vram_wdata,
    input  logic        vram_ack,
    input  logic [7:0]  vram_rdata,
    output logic        reg_we,
    output logic [2:0]  reg_num,
    output logic [7:0]  reg_data,
    input  logic        vblank,
    input  logic        int_en,
    input  logic [6:0]  spr_status,
    output logic        n_int
);
    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;
    state_t r_state, w_state_nxt;

    logic        r_prev_term, r_latch, r_frame, r_wait_n, r_n_int, r_reg_we;
    logic [7:0]  r_dout, r_first, r_buf, r_wdata, r_reg_data;
    logic [2:0]  r_reg_num;
    logic [13:0] r_addr, r_addr_new;
    logic        r_addr_pend;
    logic        r_slot_vld, r_slot_we, r_slot_dread;
    logic [7:0]  r_slot_data;

    logic        w_term, w_acc, w_dwr, w_drd, w_cwr, w_srd;
    logic        w_reg_wr, w_addr_wr, w_pf, w_ack;
    logic        w_op_new, w_idle_free, w_start_new, w_start_slot, w_slot_load, w_issue;
    logic        w_iss_we, w_iss_dread;
    logic [7:0]  w_iss_data;
    logic [13:0] w_addr_val;

    // An access acts once, on the first ce cycle its decode term is seen high.
    assign w_term = (cs_data | cs_ctrl) & (io_rd | io_wr);
    assign w_acc  = ce & w_term & ~r_prev_term;
    assign w_dwr  = w_acc & cs_data & io_wr;
    assign w_drd  = w_acc & cs_data & ~io_wr;
    assign w_cwr  = w_acc & ~cs_data & cs_ctrl & io_wr;
    assign w_srd  = w_acc & ~cs_data & cs_ctrl & ~io_wr;

    assign w_reg_wr   = w_cwr & r_latch & din[7];
    assign w_addr_wr  = w_cwr & r_latch & ~din[7];
    assign w_pf       = w_addr_wr & ~din[6];
    assign w_addr_val = {din[5:0], r_first};

    assign w_ack = vram_ack & (r_state != S_IDLE);

    // New VRAM work starts at once when idle with an empty slot; otherwise it waits in the slot.
    assign w_op_new     = w_dwr | w_drd | w_pf;
    assign w_idle_free  = (r_state == S_IDLE) & ~r_slot_vld;
    assign w_start_new  = w_op_new & w_idle_free;
    assign w_start_slot = (r_state == S_IDLE) & r_slot_vld;
    assign w_slot_load  = w_op_new & ~w_idle_free;
    assign w_issue      = w_start_new | w_start_slot;
    assign w_iss_we     = w_start_slot ? r_slot_we    : w_dwr;
    assign w_iss_dread  = w_start_slot ? r_slot_dread : w_drd;
    assign w_iss_data   = w_start_slot ? r_slot_data  : din;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        vram_req    = 1'b0;
        vram_we     = 1'b0;
        case (r_state)
            S_IDLE: if (w_issue) w_state_nxt = w_iss_we ? S_WR : S_RD;
            S_WR: begin
                vram_req = 1'b1;
                vram_we  = 1'b1;
                if (vram_ack) w_state_nxt = S_IDLE;
            end
            S_RD: begin
                vram_req = 1'b1;
                if (vram_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_term  <= 1'b0;
            r_latch      <= 1'b0;
            r_first      <= 8'h00;
            r_frame      <= 1'b0;
            r_n_int      <= 1'b1;
            r_dout       <= 8'h00;
            r_buf        <= 8'h00;
            r_wait_n     <= 1'b1;
            r_addr       <= 14'h0000;
            r_addr_new   <= 14'h0000;
            r_addr_pend  <= 1'b0;
            r_wdata      <= 8'h00;
            r_reg_we     <= 1'b0;
            r_reg_num    <= 3'd0;
            r_reg_data   <= 8'h00;
            r_slot_vld   <= 1'b0;
            r_slot_we    <= 1'b0;
            r_slot_dread <= 1'b0;
            r_slot_data  <= 8'h00;
        end else begin
            r_reg_we <= 1'b0;
            if (ce) r_prev_term <= w_term;

            // A vblank in the same cycle as a status read wins, so the flag is not lost.
            if (w_srd) begin
                r_dout  <= {r_frame, spr_status};
                r_frame <= 1'b0;
            end
            if (vblank) r_frame <= 1'b1;
            r_n_int <= ~(r_frame & int_en);

            if (w_cwr) begin
                r_latch <= ~r_latch;
                if (!r_latch) r_first <= din;
            end
            if (w_srd | w_dwr | w_drd) r_latch <= 1'b0;

            if (w_reg_wr) begin
                r_reg_we   <= 1'b1;
                r_reg_num  <= din[2:0];
                r_reg_data <= r_first;
            end

            if (w_ack) begin
                if (r_state == S_RD) r_buf <= vram_rdata;
                if (r_addr_pend) begin
                    r_addr      <= r_addr_new;
                    r_addr_pend <= 1'b0;
                end else begin
                    r_addr <= r_addr + 14'd1;
                end
            end
            // The pointer must not move under an in-flight request; a new address waits for its ack.
            if (w_addr_wr) begin
                if (r_state == S_IDLE || w_ack) begin
                    r_addr      <= w_addr_val;
                    r_addr_pend <= 1'b0;
                end else begin
                    r_addr_new  <= w_addr_val;
                    r_addr_pend <= 1'b1;
                end
            end

            if (w_issue) begin
                if (w_iss_we) begin
                    r_wdata <= w_iss_data;
                    r_buf   <= w_iss_data;
                end
                if (w_iss_dread) r_dout <= r_buf;
            end

            if (w_start_slot) r_slot_vld <= 1'b0;
            if (w_slot_load) begin
                r_slot_vld   <= 1'b1;
                r_slot_we    <= w_dwr;
                r_slot_dread <= w_drd;
                r_slot_data  <= din;
            end

            if (w_ack | w_start_slot) r_wait_n <= 1'b1;
            if (w_slot_load)          r_wait_n <= 1'b0;
        end
    end

    assign dout       = r_dout;
    assign wait_n     = r_wait_n;
    assign vram_addr  = r_addr;
    assign vram_wdata = r_wdata;
    assign reg_we     = r_reg_we;
    assign reg_num    = r_reg_num;
    assign reg_data   = r_reg_data;
    assign n_int      = r_n_int;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port: a behavioural model of the port rules predicts VRAM traffic,
// register writes and read data, and a per-cycle monitor checks the DUT against it.
module tb_vdp_cpu_port;
    logic        clk = 1'b0;
    logic        reset, ce, cs_data, cs_ctrl, io_rd, io_wr, vblank, int_en;
    logic [7:0]  din, dout, vram_wdata, vram_rdata, reg_data;
    logic [6:0]  spr_status;
    logic        wait_n, vram_req, vram_we, vram_ack, reg_we, n_int;
    logic [13:0] vram_addr;
    logic [2:0]  reg_num;

    vdp_cpu_port dut (
        .clk(clk), .reset(reset), .ce(ce), .cs_data(cs_data), .cs_ctrl(cs_ctrl),
        .io_rd(io_rd), .io_wr(io_wr), .din(din), .dout(dout), .wait_n(wait_n),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
        .reg_we(reg_we), .reg_num(reg_num), .reg_data(reg_data), .vblank(vblank),
        .int_en(int_en), .spr_status(spr_status), .n_int(n_int)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- arbiter with configurable ack delay ----------------
    bit [7:0]    vmem [0:16383];
    int          ack_delay = 0;
    int          wcnt = 0;
    logic        pre_we = 1'b0;
    logic [13:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    initial begin
        vram_ack   = 1'b0;
        vram_rdata = 8'h00;
    end

    always @(posedge clk) begin
        vram_ack <= 1'b0;
        if (pre_we) vmem[pre_addr] <= pre_data;
        if (vram_req && !vram_ack && !reset) begin
            if (wcnt >= ack_delay) begin
                vram_ack <= 1'b1;
                wcnt     <= 0;
                if (vram_we) vmem[vram_addr] <= vram_wdata;
                else         vram_rdata      <= vmem[vram_addr];
            end else begin
                wcnt <= wcnt + 1;
            end
        end else if (!vram_req) begin
            wcnt <= 0;
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {logic we; logic [13:0] addr; logic [7:0] data;} vtx_t;
    vtx_t        exp_q[$];
    logic [10:0] exp_reg[$];
    bit [7:0]    mem_m [0:16383];
    logic [13:0] m_addr = '0;
    logic        m_latch = 1'b0;
    logic [7:0]  m_first = '0;
    logic [7:0]  m_buf = '0;
    logic        m_frame = 1'b0;

    task automatic m_prefetch();
        exp_q.push_back('{we: 1'b0, addr: m_addr, data: 8'h00});
        m_buf  = mem_m[m_addr];
        m_addr = m_addr + 14'd1;
    endtask

    task automatic m_ctrl_wr(input logic [7:0] d);
        if (!m_latch) begin
            m_first = d;
            m_latch = 1'b1;
        end else begin
            m_latch = 1'b0;
            if (d[7]) exp_reg.push_back({d[2:0], m_first});
            else begin
                m_addr = {d[5:0], m_first};
                if (!d[6]) m_prefetch();
            end
        end
    endtask

    // ---------------- per-cycle monitor ----------------
    logic        prev_req = 1'b0, prev_regwe = 1'b0, hold_we = 1'b0;
    logic [13:0] hold_addr = '0;
    logic [7:0]  hold_wd = '0;
    int          n_done = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (vram_req && prev_req) begin
                chk("req_stable_addr", vram_addr, hold_addr);
                chk("req_stable_we", vram_we, hold_we);
                if (vram_we) chk("req_stable_wdata", vram_wdata, hold_wd);
            end
            if (vram_req && !prev_req) begin
                hold_addr = vram_addr;
                hold_we   = vram_we;
                hold_wd   = vram_wdata;
            end
            if (vram_req && vram_ack) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL vram_unexpected: got we=%0b addr=%0h, expected no transaction",
                             vram_we, vram_addr);
                end else begin
                    vtx_t e;
                    e = exp_q.pop_front();
                    chk("vram_we", vram_we, e.we);
                    chk("vram_addr", vram_addr, e.addr);
                    if (e.we) chk("vram_wdata", vram_wdata, e.data);
                end
            end
            if (reg_we) begin
                chk("reg_we_width", prev_regwe, 1'b0);
                if (exp_reg.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL reg_unexpected: got reg%0d=%0h, expected no register write",
                             reg_num, reg_data);
                end else begin
                    logic [10:0] r;
                    r = exp_reg.pop_front();
                    chk("reg_num", reg_num, r[10:8]);
                    chk("reg_data", reg_data, r[7:0]);
                end
            end
        end
        prev_req   = vram_req;
        prev_regwe = reg_we;
    end

    // ---------------- CPU bus tasks (called at a negedge) ----------------
    task automatic bus_idle();
        cs_data = 1'b0; cs_ctrl = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
    endtask

    task automatic access(input bit ctrl, input bit wr, input logic [7:0] d, input bit lat);
        int n;
        cs_ctrl = ctrl; cs_data = !ctrl; io_wr = wr; io_rd = !wr; din = d;
        @(negedge clk);
        if (lat) begin
            chk("lat_req_rise", vram_req, 1'b1);
            chk("lat_ack_pending", vram_ack, 1'b0);
            @(negedge clk);
            chk("lat_ack", vram_ack, 1'b1);
            @(negedge clk);
            chk("lat_req_fall", vram_req, 1'b0);
        end else begin
            repeat (3) @(negedge clk);
        end
        n = 0;
        while (!wait_n && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!wait_n) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: wait_n still %0b after %0d cycles, expected 1", wait_n, n);
        end
        bus_idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic wr_ctrl(input logic [7:0] d);
        m_ctrl_wr(d);
        access(1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic wr_data(input logic [7:0] d, input bit lat);
        m_latch = 1'b0;
        exp_q.push_back('{we: 1'b1, addr: m_addr, data: d});
        mem_m[m_addr] = d;
        m_buf  = d;
        m_addr = m_addr + 14'd1;
        access(1'b0, 1'b1, d, lat);
    endtask

    task automatic rd_data(input string name);
        logic [7:0] e;
        e = m_buf;
        m_latch = 1'b0;
        m_prefetch();
        access(1'b0, 1'b0, 8'h00, 1'b0);
        chk(name, dout, e);
    endtask

    task automatic rd_status(input string name);
        logic [7:0] e;
        e = {m_frame, spr_status};
        m_frame = 1'b0;
        m_latch = 1'b0;
        access(1'b1, 1'b0, 8'h00, 1'b0);
        chk(name, dout, e);
    endtask

    task automatic preload(input logic [13:0] a, input logic [7:0] d);
        mem_m[a] = d;
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    initial begin
        logic [13:0] a0;
        int done0, n;
        reset = 1'b1; ce = 1'b1; vblank = 1'b0; int_en = 1'b0; spr_status = 7'h00; din = 8'h00;
        bus_idle();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_dout", dout, 8'h00);
        chk("rst_wait_n", wait_n, 1'b1);
        chk("rst_vram_req", vram_req, 1'b0);
        chk("rst_vram_we", vram_we, 1'b0);
        chk("rst_vram_addr", vram_addr, 14'h0000);
        chk("rst_vram_wdata", vram_wdata, 8'h00);
        chk("rst_reg_we", reg_we, 1'b0);
        chk("rst_reg_num", reg_num, 3'd0);
        chk("rst_reg_data", reg_data, 8'h00);
        chk("rst_n_int", n_int, 1'b1);

        // Address setup and write burst across the 14-bit wrap
        wr_ctrl(8'hFF);
        wr_ctrl(8'h7F);
        chk("burst_addr_set", vram_addr, 14'h3FFF);
        wr_data(8'hAA, 1'b1);
        wr_data(8'h55, 1'b0);
        chk("burst_addr_model", vram_addr, m_addr);
        chk("burst_addr_lit", vram_addr, 14'h0001);
        chk("burst_mem_3fff", vmem[14'h3FFF], 8'hAA);
        chk("burst_mem_0000", vmem[14'h0000], 8'h55);

        // Read-ahead
        preload(14'h0100, 8'h11);
        preload(14'h0101, 8'h22);
        wr_ctrl(8'h00);
        wr_ctrl(8'h01);
        rd_data("rd1_model");
        chk("rd1_lit", dout, 8'h11);
        rd_data("rd2_model");
        chk("rd2_lit", dout, 8'h22);
        chk("rd_addr_model", vram_addr, m_addr);

        // Register write leaves the VRAM pointer alone
        a0 = vram_addr;
        wr_ctrl(8'hE0);
        wr_ctrl(8'h81);
        chk("reg_addr_kept", vram_addr, a0);
        chk("reg_num_lit", reg_num, 3'd1);
        chk("reg_data_lit", reg_data, 8'hE0);
        chk("reg_q_drained", exp_reg.size(), 0);

        // Interrupt and status
        int_en = 1'b1; spr_status = 7'h45;
        vblank = 1'b1; m_frame = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        chk("nint_lag", n_int, 1'b1);
        @(negedge clk);
        chk("nint_asserted", n_int, 1'b0);
        rd_status("stat1_model");
        chk("stat1_lit", dout, 8'hC5);
        chk("nint_cleared", n_int, 1'b1);
        rd_status("stat2_model");
        chk("stat2_lit", dout, 8'h45);

        // vblank coincident with a status read: old flag is read, flag ends set
        cs_ctrl = 1'b1; io_rd = 1'b1; vblank = 1'b1;
        m_latch = 1'b0;
        @(negedge clk);
        vblank = 1'b0;
        repeat (3) @(negedge clk);
        bus_idle();
        m_frame = 1'b1;
        repeat (2) @(negedge clk);
        chk("vbl_race_dout", dout, 8'h45);
        chk("vbl_race_nint", n_int, 1'b0);
        int_en = 1'b0;
        @(negedge clk);
        chk("ie_off_nint", n_int, 1'b1);
        int_en = 1'b1;
        @(negedge clk);
        chk("ie_on_nint", n_int, 1'b0);
        rd_status("stat3_model");
        chk("stat3_lit", dout, 8'hC5);

        // Status read resets the byte latch
        wr_ctrl(8'h12);
        rd_status("stat4_model");
        wr_ctrl(8'h34);
        wr_ctrl(8'h40);
        chk("latch_addr_lit", vram_addr, 14'h0034);
        chk("latch_addr_model", vram_addr, m_addr);
        chk("latch_no_reg", exp_reg.size(), 0);

        // Control address write while a VRAM write is in flight
        ack_delay = 25;
        wr_data(8'hC3, 1'b0);
        wr_ctrl(8'h00);
        wr_ctrl(8'h43);
        repeat (30) @(negedge clk);
        chk("busy_addr_lit", vram_addr, 14'h0300);
        chk("busy_addr_model", vram_addr, m_addr);
        chk("busy_mem", vmem[14'h0034], 8'hC3);

        // Stall: second data write while the first is unacknowledged
        ack_delay = 20;
        wr_ctrl(8'h00);
        wr_ctrl(8'h42);
        done0 = n_done;
        wr_data(8'hA1, 1'b0);
        exp_q.push_back('{we: 1'b1, addr: m_addr, data: 8'hB2});
        mem_m[m_addr] = 8'hB2; m_buf = 8'hB2; m_addr = m_addr + 14'd1;
        cs_data = 1'b1; io_wr = 1'b1; din = 8'hB2;
        @(negedge clk);
        chk("stall_wait_low", wait_n, 1'b0);
        chk("stall_first_open", n_done, done0);
        n = 0;
        while (!wait_n && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_release_at_ack", n_done, done0 + 1);
        bus_idle();
        n = 0;
        while (n_done < done0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_second_done", n_done, done0 + 2);
        repeat (2) @(negedge clk);
        chk("stall_mem0", vmem[14'h0200], 8'hA1);
        chk("stall_mem1", vmem[14'h0201], 8'hB2);
        chk("stall_addr", vram_addr, 14'h0202);

        // Bus activity with ce low is ignored
        ack_delay = 0;
        ce = 1'b0;
        cs_data = 1'b1; io_wr = 1'b1; din = 8'hEE;
        repeat (3) @(negedge clk);
        bus_idle();
        @(negedge clk);
        ce = 1'b1;
        repeat (5) @(negedge clk);
        chk("ce_gate_addr", vram_addr, m_addr);
        chk("ce_gate_mem", vmem[14'h0202], 8'h00);

        // Reset mid-operation with a pending slot
        ack_delay = 50;
        wr_data(8'h77, 1'b0);
        cs_data = 1'b1; io_wr = 1'b1; din = 8'h88;
        @(negedge clk);
        chk("rst_mid_wait_low", wait_n, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_drop", vram_req, 1'b0);
        chk("rst_mid_wait_high", wait_n, 1'b1);
        reset = 1'b0;
        bus_idle();
        exp_q.delete();
        m_addr = '0; m_latch = 1'b0; m_buf = '0; m_frame = 1'b0;
        repeat (60) @(negedge clk);
        chk("rst_mid_idle", vram_req, 1'b0);
        chk("rst_mid_addr", vram_addr, m_addr);
        chk("rst_mid_mem", vmem[14'h0202], 8'h00);

        chk("vram_q_drained", exp_q.size(), 0);
        chk("reg_q_final", exp_reg.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end
endmodule
